// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// The result is computed at the start edge and held back until the configured latency elapses.
module mul_div_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             move_to,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata
);

    localparam logic [2:0] OP_MUL    = 3'd1;
    localparam logic [2:0] OP_MULU   = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd3;
    localparam logic [2:0] OP_DIVU   = 3'd4;
    localparam logic [2:0] OP_SEL_HI = 3'd5;
    localparam logic [2:0] OP_SEL_LO = 3'd6;

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] pend_hi_q, pend_lo_q;
    logic             pend_wr_q;

    logic             op_valid;
    logic             is_div;
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b, dvd, dvs;
    logic [WIDTH-1:0] uq, ur;
    logic [WIDTH-1:0] res_hi_d, res_lo_d;
    logic             res_wr_d;

    assign op_valid = (op >= OP_MUL) && (op <= OP_DIVU);
    assign is_div   = (op == OP_DIV) || (op == OP_DIVU);

    assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Signed divide goes through the unsigned divider on magnitudes; MIN_INT/-1
    // falls out naturally as 0x8000.. with remainder 0.
    assign a_neg = a[WIDTH-1];
    assign b_neg = b[WIDTH-1];
    assign abs_a = a_neg ? (~a + 1'b1) : a;
    assign abs_b = b_neg ? (~b + 1'b1) : b;
    assign dvd   = (op == OP_DIV) ? abs_a : a;
    assign dvs   = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : ((op == OP_DIV) ? abs_b : b);
    assign uq    = dvd / dvs;
    assign ur    = dvd % dvs;

    always_comb begin
        res_hi_d = '0;
        res_lo_d = '0;
        res_wr_d = 1'b1;
        case (op)
            OP_MUL:  {res_hi_d, res_lo_d} = prod_s;
            OP_MULU: {res_hi_d, res_lo_d} = prod_u;
            OP_DIV: begin
                res_lo_d = (a_neg ^ b_neg) ? (~uq + 1'b1) : uq;
                res_hi_d = a_neg ? (~ur + 1'b1) : ur;
            end
            OP_DIVU: begin
                res_lo_d = uq;
                res_hi_d = ur;
            end
            default: ;
        endcase
        if (is_div && (b == '0))
            res_wr_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && op_valid) begin
                        state_q   <= S_RUN;
                        busy_q    <= 1'b1;
                        cnt_q     <= is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                        pend_hi_q <= res_hi_d;
                        pend_lo_q <= res_lo_d;
                        pend_wr_q <= res_wr_d;
                    end else if (move_to) begin
                        if (op == OP_SEL_HI)
                            hi_q <= a;
                        else if (op == OP_SEL_LO)
                            lo_q <= a;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        if (pend_wr_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign rdata = (op == OP_SEL_HI) ? hi_q : lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed literal cases plus randomized traffic against an
// arithmetic reference model checked every cycle.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        move_to = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0, b = '0;
    logic        busy;
    logic [31:0] hi, lo, rdata;

    mul_div_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .move_to(move_to), .op(op),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo), .rdata(rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: {commit, hi, lo} from plain 64-bit arithmetic.
    function automatic logic [64:0] calc(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy, p, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        calc = '0;
        case (o)
            3'd1: begin p = sx * sy; calc = {1'b1, p[63:32], p[31:0]}; end
            3'd2: begin p = ux * uy; calc = {1'b1, p[63:32], p[31:0]}; end
            3'd3: if (y != 0) begin q = sx / sy; r = sx % sy; calc = {1'b1, r[31:0], q[31:0]}; end
            3'd4: if (y != 0) begin q = ux / uy; r = ux % uy; calc = {1'b1, r[31:0], q[31:0]}; end
            default: calc = '0;
        endcase
    endfunction

    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_pwr;
    int          m_rem = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_hi <= '0; m_lo <= '0; m_rem <= 0;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1 && m_pwr) begin
                m_hi <= m_phi; m_lo <= m_plo;
            end
        end else if (start && op >= 3'd1 && op <= 3'd4) begin
            {m_pwr, m_phi, m_plo} <= calc(op, a, b);
            m_rem <= (op <= 3'd2) ? 5 : 10;
        end else if (move_to) begin
            if (op == 3'd5) m_hi <= a;
            else if (op == 3'd6) m_lo <= a;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(m_rem > 0));
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
            chk("rdata", 64'(rdata), 64'((op == 3'd5) ? m_hi : m_lo));
        end
    end

    task automatic issue(input logic s, input logic mv, input logic [2:0] o,
                         input logic [31:0] x, input logic [31:0] y);
        @(posedge clk); #2;
        start = s; move_to = mv; op = o; a = x; b = y;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        repeat (60) begin
            @(negedge clk);
            if (!busy) break;
            cycles++;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int n, input logic [31:0] eh, input logic [31:0] el);
        int c;
        issue(1'b1, 1'b0, o, x, y);
        issue(1'b0, 1'b0, 3'd0, '0, '0);
        wait_idle(c);
        chk({name, "_cycles"}, 64'(c), 64'(n));
        chk({name, "_hi"}, 64'(hi), 64'(eh));
        chk({name, "_lo"}, 64'(lo), 64'(el));
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: rnd_val = 32'h0;
            1: rnd_val = 32'h1;
            2: rnd_val = 32'hFFFF_FFFF;
            3: rnd_val = 32'h8000_0000;
            4: rnd_val = 32'h7FFF_FFFF;
            5: rnd_val = 32'($urandom_range(0, 20));
            default: rnd_val = $urandom;
        endcase
    endfunction

    initial begin
        int c;
        @(posedge clk); #2;
        chk_en = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);

        run_op("mult", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(1'b0, 1'b1, 3'd5, 32'h11, '0);
        issue(1'b0, 1'b1, 3'd6, 32'h22, '0);
        issue(1'b0, 1'b0, 3'd5, '0, '0);
        @(negedge clk);
        chk("mthi_rdata", 64'(rdata), 64'h11);
        run_op("divu_zero", 3'd4, 32'd7, 32'd0, 10, 32'h11, 32'h22);

        // Writes and starts arriving mid-operation must be dropped.
        issue(1'b1, 1'b0, 3'd1, 32'd3, 32'd4);
        issue(1'b0, 1'b1, 3'd5, 32'h55, '0);
        issue(1'b1, 1'b0, 3'd4, 32'd100, 32'd7);
        issue(1'b0, 1'b0, 3'd0, '0, '0);
        wait_idle(c);
        chk("busy_ignore_hi", 64'(hi), 64'd0);
        chk("busy_ignore_lo", 64'(lo), 64'd12);

        run_op("div_minint", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);

        issue(1'b1, 1'b0, 3'd1, 32'd6, 32'd7);
        issue(1'b0, 1'b0, 3'd0, '0, '0);
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("abort_nolate_lo", 64'(lo), 64'd0);

        for (int i = 0; i < 600; i++) begin
            logic [2:0] o;
            int r;
            o = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 9);
            @(posedge clk); #2;
            op = o; a = rnd_val(); b = rnd_val();
            start = (r < 4) && (o < 3'd5);
            move_to = (r >= 3) && (r < 7);
            reset = ($urandom_range(0, 149) == 0);
        end
        issue(1'b0, 1'b0, 3'd0, '0, '0);
        reset = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
